// File: rtl/product_display_scroller.sv
// ---------------------------------------------------------------------------
// product_display_scroller
//
// This block sits behind the multiplier. It converts the 16-bit product to a
// sign and five BCD digits using an iterative double-dabble converter. It then
// drives a four-digit multiplexed seven-segment display.
//   - The leftmost digit shows the sign: '-' or blank.
//   - The other three digits show a 3-digit window onto the 5-digit magnitude.
//     The shift pulses scroll that window.
//
// Parameters
//   REFRESH_DIV  cycles each digit stays lit before the mux advances (>= 2)
//   SIGNED       1 = product is two's complement, 0 = unsigned
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous reset, active low
//   product      multiplier result, sampled when load is high
//   load         single-cycle strobe: capture product, start conversion
//   shift_left   single-cycle pulse: window toward more significant digits
//   shift_right  single-cycle pulse: window toward less significant digits
//   segments     active-low segment drive {g,f,e,d,c,b,a}
//   anodes       active-low one-hot digit enable, bit 0 = rightmost digit
//   busy         high while a conversion is in progress
//   win_pos      current window position, 0..2
// ---------------------------------------------------------------------------
module product_display_scroller #(
  parameter int REFRESH_DIV = 100000,
  parameter bit SIGNED      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] product,
  input  logic        load,
  input  logic        shift_left,
  input  logic        shift_right,
  output logic [6:0]  segments,
  output logic [3:0]  anodes,
  output logic        busy,
  output logic [1:0]  win_pos
);

  localparam int              CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_IDLE,
    ST_CONV
  } convState_t;

  convState_t        convState_q;
  logic [3:0]        step_q;
  logic [15:0]       mag_q;
  logic [19:0]       bcd_q;
  logic              signWork_q;
  logic              dispSign_q;
  logic [19:0]       dispDigits_q;
  logic              busy_q;

  logic              loadSign_d;
  logic [15:0]       loadMag_d;
  logic [19:0]       adjBcd_d;
  logic [35:0]       dabble_d;

  logic [1:0]        winPos_q;
  logic [1:0]        winPos_d;

  logic [CNT_W-1:0]  refreshCnt_q;
  logic [CNT_W-1:0]  refreshCnt_d;
  logic [1:0]        digitIdx_q;
  logic [1:0]        digitIdx_d;
  logic [2:0]        windowSel_d;
  logic [3:0]        selNibble_d;
  logic [6:0]        segments_q;
  logic [6:0]        segments_d;
  logic [3:0]        anodes_q;
  logic [3:0]        anodes_d;

  // Seven-segment glyphs for the decimal digits, active low.
  // Nibbles above 9 cannot come out of the converter, so they map to blank.
  function automatic logic [6:0] sevenSeg(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Split the incoming product into a sign and an unsigned magnitude.
  // Negating 16'h8000 wraps back to 16'h8000, which read unsigned is
  // 32768, so the most negative product needs no special case.
  always_comb begin
    loadSign_d = SIGNED && product[15];
    loadMag_d  = loadSign_d ? (~product + 16'd1) : product;
  end

  // One double-dabble step.
  //   - Each BCD nibble that is 5 or more gets 3 added, so it carries
  //     correctly into the next decade when shifted.
  //   - Then the whole {bcd, magnitude} pair shifts left by one.
  //   - After 16 steps the top 20 bits hold the five decimal digits.
  always_comb begin
    adjBcd_d = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adjBcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    dabble_d = {adjBcd_d, mag_q} << 1;
  end

  // Conversion FSM.
  //   - load always restarts the conversion from scratch, even mid-conversion.
  //   - The visible display register changes only when all 16 steps complete.
  //     An aborted conversion therefore never shows partial digits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      convState_q  <= ST_IDLE;
      step_q       <= 4'd0;
      mag_q        <= 16'd0;
      bcd_q        <= 20'd0;
      signWork_q   <= 1'b0;
      dispSign_q   <= 1'b0;
      dispDigits_q <= 20'd0;
      busy_q       <= 1'b0;
    end else if (load) begin
      convState_q <= ST_CONV;
      step_q      <= 4'd0;
      mag_q       <= loadMag_d;
      bcd_q       <= 20'd0;
      signWork_q  <= loadSign_d;
      busy_q      <= 1'b1;
    end else begin
      case (convState_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
        end
        ST_CONV: begin
          {bcd_q, mag_q} <= dabble_d;
          step_q         <= step_q + 4'd1;
          if (step_q == 4'd15) begin
            dispDigits_q <= dabble_d[35:16];
            dispSign_q   <= signWork_q;
            convState_q  <= ST_IDLE;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          convState_q <= ST_IDLE;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Window position update.
  //   - The window saturates at 0 and 2.
  //   - Opposing pulses in the same cycle cancel.
  //   - A load always snaps the window back to the least significant digits.
  always_comb begin
    winPos_d = winPos_q;
    if (load) begin
      winPos_d = 2'd0;
    end else if (shift_left && !shift_right) begin
      if (winPos_q != 2'd2) begin
        winPos_d = winPos_q + 2'd1;
      end
    end else if (shift_right && !shift_left) begin
      if (winPos_q != 2'd0) begin
        winPos_d = winPos_q - 2'd1;
      end
    end
  end

  // Window position register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      winPos_q <= 2'd0;
    end else begin
      winPos_q <= winPos_d;
    end
  end

  // Refresh timing: the digit index advances once every REFRESH_DIV cycles.
  always_comb begin
    refreshCnt_d = refreshCnt_q + CNT_W'(1);
    digitIdx_d   = digitIdx_q;
    if (refreshCnt_q == CNT_LAST) begin
      refreshCnt_d = '0;
      digitIdx_d   = digitIdx_q + 2'd1;
    end
  end

  // Choose what the next selected digit should show.
  //   - The glyph is computed for the index that is about to be active.
  //     This keeps the registered segments and anodes in step with each other.
  //   - Digits 0..2 view d[win_pos + index].
  //   - Digit 3 carries the sign.
  always_comb begin
    windowSel_d = {1'b0, winPos_q} + {1'b0, digitIdx_d};
    case (windowSel_d)
      3'd0:    selNibble_d = dispDigits_q[3:0];
      3'd1:    selNibble_d = dispDigits_q[7:4];
      3'd2:    selNibble_d = dispDigits_q[11:8];
      3'd3:    selNibble_d = dispDigits_q[15:12];
      3'd4:    selNibble_d = dispDigits_q[19:16];
      default: selNibble_d = 4'd0;
    endcase

    if (digitIdx_d == 2'd3) begin
      segments_d = dispSign_q ? SEG_DASH : SEG_BLANK;
    end else begin
      segments_d = sevenSeg(selNibble_d);
    end

    anodes_d = ~(4'b0001 << digitIdx_d);
  end

  // Display multiplexer registers.
  // Segments are refreshed every cycle, so a new value shows up on the next
  // edge while its digit is lit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refreshCnt_q <= '0;
      digitIdx_q   <= 2'd0;
      segments_q   <= 7'b1000000;
      anodes_q     <= 4'b1110;
    end else begin
      refreshCnt_q <= refreshCnt_d;
      digitIdx_q   <= digitIdx_d;
      segments_q   <= segments_d;
      anodes_q     <= anodes_d;
    end
  end

  assign segments = segments_q;
  assign anodes   = anodes_q;
  assign busy     = busy_q;
  assign win_pos  = winPos_q;

endmodule
